micro_sequencer: RTL and testbench

Variable-length micro-sequencer for the 8-bit SAP datapath; replaces the fixed six-step control unit. It steps T-states, decodes the IR opcode into the 12-bit control word, latches ALU flags and ends each instruction as soon as its last micro-op is issued. It drives pc, memory/MAR, ir, reg_a, reg_b and adder enables/loads. The clock module consumes its `hlt` output.

---
 rtl/sap_pkg.sv | 58 +++++
 rtl/micro_decode.sv | 110 +++++++++++
 rtl/micro_sequencer.sv | 74 +++++++
 tb/tb_micro_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared types and constants for the SAP micro-sequencer: opcodes, T-states,
// control-word bit positions and the control-word struct.
package sap_pkg;

   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned CTRL_W   = 12;
   localparam int unsigned STATE_W  = 3;

   localparam int unsigned CB_HLT       = 11;
   localparam int unsigned CB_PC_INC    = 10;
   localparam int unsigned CB_PC_EN     = 9;
   localparam int unsigned CB_MAR_LOAD  = 8;
   localparam int unsigned CB_MEM_EN    = 7;
   localparam int unsigned CB_IR_LOAD   = 6;
   localparam int unsigned CB_IR_EN     = 5;
   localparam int unsigned CB_A_LOAD    = 4;
   localparam int unsigned CB_A_EN      = 3;
   localparam int unsigned CB_B_LOAD    = 2;
   localparam int unsigned CB_ADDER_SUB = 1;
   localparam int unsigned CB_ADDER_EN  = 0;

   typedef enum logic [OPCODE_W-1:0] {
      OP_NOP = 4'h0,
      OP_LDA = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_JMP = 4'h4,
      OP_JZ  = 4'h5,
      OP_JC  = 4'h6,
      OP_HLT = 4'hF
   } opcode_e;

   typedef enum logic [STATE_W-1:0] {
      T0   = 3'd0,
      T1   = 3'd1,
      T2   = 3'd2,
      T3   = 3'd3,
      T4   = 3'd4,
      T5   = 3'd5,
      HALT = 3'd6
   } tstate_e;

   typedef struct packed {
      logic hlt;
      logic pc_inc;
      logic pc_en;
      logic mar_load;
      logic mem_en;
      logic ir_load;
      logic ir_en;
      logic a_load;
      logic a_en;
      logic b_load;
      logic adder_sub;
      logic adder_en;
   } ctrl_t;

endpackage

// File: rtl/micro_decode.sv
// Combinational micro-op decode: (state, opcode, flags) -> control word,
// branch load and end-of-instruction. Branch opcodes need SAP_BRANCH_EN.
module micro_decode
   import sap_pkg::*;
(
   input  tstate_e             state,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                flag_z,
   input  logic                flag_c,
   output ctrl_t               ctrl,
   output logic                pc_load,
   output logic                last_step
);

   logic [CTRL_W-1:0] w;
   logic              has_exec;

   // Opcodes that continue past the common fetch.
   always_comb begin
      has_exec = 1'b0;
      case (opcode)
         OP_LDA, OP_ADD, OP_SUB, OP_HLT: has_exec = 1'b1;
`ifdef SAP_BRANCH_EN
         OP_JMP, OP_JZ, OP_JC:           has_exec = 1'b1;
`endif
         default:                        has_exec = 1'b0;
      endcase
   end

   always_comb begin
      w         = '0;
      pc_load   = 1'b0;
      last_step = 1'b0;
      case (state)
         T0: begin
            w[CB_PC_EN]    = 1'b1;
            w[CB_MAR_LOAD] = 1'b1;
         end
         T1: w[CB_PC_INC] = 1'b1;
         T2: begin
            w[CB_MEM_EN]  = 1'b1;
            w[CB_IR_LOAD] = 1'b1;
            last_step     = !has_exec;
         end
         T3: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB: begin
                  w[CB_IR_EN]    = 1'b1;
                  w[CB_MAR_LOAD] = 1'b1;
               end
               OP_HLT: begin
                  w[CB_HLT] = 1'b1;
                  last_step = 1'b1;
               end
`ifdef SAP_BRANCH_EN
               OP_JMP: begin
                  w[CB_IR_EN] = 1'b1;
                  pc_load     = 1'b1;
                  last_step   = 1'b1;
               end
               OP_JZ: begin
                  w[CB_IR_EN] = 1'b1;
                  pc_load     = flag_z;
                  last_step   = 1'b1;
               end
               OP_JC: begin
                  w[CB_IR_EN] = 1'b1;
                  pc_load     = flag_c;
                  last_step   = 1'b1;
               end
`endif
               default: last_step = 1'b1;
            endcase
         end
         T4: begin
            case (opcode)
               OP_LDA: begin
                  w[CB_MEM_EN] = 1'b1;
                  w[CB_A_LOAD] = 1'b1;
                  last_step    = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  w[CB_MEM_EN] = 1'b1;
                  w[CB_B_LOAD] = 1'b1;
               end
               default: last_step = 1'b1;
            endcase
         end
         T5: begin
            if (opcode == OP_ADD || opcode == OP_SUB) begin
               w[CB_ADDER_EN]  = 1'b1;
               w[CB_A_LOAD]    = 1'b1;
               w[CB_ADDER_SUB] = (opcode == OP_SUB);
            end
            last_step = 1'b1;
         end
         HALT: w[CB_HLT] = 1'b1;
         default: last_step = 1'b1;
      endcase
   end

`ifndef SAP_BRANCH_EN
   // Flags only steer conditional branches.
   logic unused_flags;
   assign unused_flags = flag_z ^ flag_c;
`endif

   assign ctrl = ctrl_t'(w);

endmodule

// File: rtl/micro_sequencer.sv
// Variable-length SAP micro-sequencer: T-state register, ALU flag latches and
// reset gating around micro_decode. Branch opcodes enabled by SAP_BRANCH_EN.
module micro_sequencer
   import sap_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                alu_zero,
   input  logic                alu_carry,
   output logic [CTRL_W-1:0]   ctrl,
   output logic                pc_load,
   output logic [STATE_W-1:0]  t_state,
   output logic                flag_z,
   output logic                flag_c
);

   tstate_e state_q, state_d;
   logic    flag_z_q, flag_z_d;
   logic    flag_c_q, flag_c_d;
   ctrl_t   dec_ctrl;
   logic    dec_pc_load;
   logic    last_step;

   micro_decode u_decode (
      .state     (state_q),
      .opcode    (opcode),
      .flag_z    (flag_z_q),
      .flag_c    (flag_c_q),
      .ctrl      (dec_ctrl),
      .pc_load   (dec_pc_load),
      .last_step (last_step)
   );

   // Next step and flag capture at the end of ADD/SUB.
   always_comb begin
      state_d  = state_q;
      flag_z_d = flag_z_q;
      flag_c_d = flag_c_q;
      if (state_q == HALT) begin
         state_d = HALT;
      end else if (state_q == T3 && opcode == OP_HLT) begin
         state_d = HALT;
      end else if (last_step || state_q == T5) begin
         state_d = T0;
      end else begin
         state_d = tstate_e'(STATE_W'(state_q) + STATE_W'(1));
      end
      if (state_q == T5 && (opcode == OP_ADD || opcode == OP_SUB)) begin
         flag_z_d = alu_zero;
         flag_c_d = alu_carry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= T0;
         flag_z_q <= 1'b0;
         flag_c_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         flag_z_q <= flag_z_d;
         flag_c_q <= flag_c_d;
      end
   end

   // Reset forces the datapath controls quiet without waiting for a clock.
   assign ctrl    = rst ? '0 : CTRL_W'(dec_ctrl);
   assign pc_load = rst ? 1'b0 : dec_pc_load;
   assign t_state = STATE_W'(state_q);
   assign flag_z  = flag_z_q;
   assign flag_c  = flag_c_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: the driver queues the expected word
// per cycle, a negedge monitor pops and compares. Honors SAP_BRANCH_EN.
module tb_micro_sequencer;

   logic        clk;
   logic        rst;
   logic [3:0]  opcode;
   logic        alu_zero;
   logic        alu_carry;
   logic [11:0] ctrl;
   logic        pc_load;
   logic [2:0]  t_state;
   logic        flag_z;
   logic        flag_c;

   micro_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .opcode    (opcode),
      .alu_zero  (alu_zero),
      .alu_carry (alu_carry),
      .ctrl      (ctrl),
      .pc_load   (pc_load),
      .t_state   (t_state),
      .flag_z    (flag_z),
      .flag_c    (flag_c)
   );

   typedef struct packed {
      logic [63:0] tag;
      logic [11:0] ctrl;
      logic        pl;
      logic [2:0]  t;
      logic        chk_t;
      logic        fz;
      logic        fc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic ez = 1'b0;
   logic ecf = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one expected entry per cycle, compared mid-cycle.
   initial begin
      exp_t e;
      logic [2:0] got_t;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            got_t = e.chk_t ? t_state : e.t;
            checks++;
            if ({ctrl, pc_load, got_t, flag_z, flag_c} !== {e.ctrl, e.pl, e.t, e.fz, e.fc}) begin
               errors++;
               $display("FAIL %s: got ctrl=%h pc_load=%b t=%0d z=%b c=%b, want ctrl=%h pc_load=%b t=%0d z=%b c=%b",
                        e.tag, ctrl, pc_load, got_t, flag_z, flag_c, e.ctrl, e.pl, e.t, e.fz, e.fc);
            end
         end
      end
   end

   task automatic cyc(input logic [63:0] tag, input logic r, input logic [3:0] op,
                      input logic z, input logic c, input logic [11:0] ec,
                      input logic epl, input logic [2:0] et, input logic chkt);
      exp_t e;
      rst       = r;
      opcode    = op;
      alu_zero  = z;
      alu_carry = c;
      e = '{tag: tag, ctrl: ec, pl: epl, t: et, chk_t: chkt, fz: ez, fc: ecf};
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Common fetch; opcode is junk until T2 since the IR is not loaded yet.
   task automatic fetch(input logic [63:0] tag, input logic [3:0] op);
      cyc(tag, 1'b0, 4'hF, 1'b1, 1'b1, 12'h300, 1'b0, 3'd0, 1'b1);
      cyc(tag, 1'b0, 4'hF, 1'b1, 1'b1, 12'h400, 1'b0, 3'd1, 1'b1);
      cyc(tag, 1'b0, op,   1'b1, 1'b1, 12'h0C0, 1'b0, 3'd2, 1'b1);
   endtask

   task automatic alu_op(input logic [63:0] tag, input logic [3:0] op,
                         input logic z, input logic c);
      fetch(tag, op);
      cyc(tag, 1'b0, op, ~z, ~c, 12'h120, 1'b0, 3'd3, 1'b1);
      cyc(tag, 1'b0, op, ~z, ~c, 12'h084, 1'b0, 3'd4, 1'b1);
      cyc(tag, 1'b0, op, z, c, (op == 4'h3) ? 12'h013 : 12'h011, 1'b0, 3'd5, 1'b1);
      ez  = z;
      ecf = c;
   endtask

   task automatic branch_op(input logic [63:0] tag, input logic [3:0] op, input logic epl);
      fetch(tag, op);
      cyc(tag, 1'b0, op, 1'b0, 1'b0, 12'h020, epl, 3'd3, 1'b1);
   endtask

   initial begin
      rst       = 1'b1;
      opcode    = 4'h0;
      alu_zero  = 1'b0;
      alu_carry = 1'b0;
      @(posedge clk);
      #1;
      cyc("RST", 1'b1, 4'h1, 1'b1, 1'b1, 12'h000, 1'b0, 3'd0, 1'b1);

      fetch("LDA", 4'h1);
      cyc("LDA", 1'b0, 4'h1, 1'b1, 1'b1, 12'h120, 1'b0, 3'd3, 1'b1);
      cyc("LDA", 1'b0, 4'h1, 1'b1, 1'b1, 12'h090, 1'b0, 3'd4, 1'b1);
      fetch("NOP", 4'h0);
      alu_op("ADD", 4'h2, 1'b0, 1'b1);
      alu_op("SUB", 4'h3, 1'b1, 1'b1);
`ifdef SAP_BRANCH_EN
      branch_op("JZ_T", 4'h5, 1'b1);
      branch_op("JC_T", 4'h6, 1'b1);
      branch_op("JMP", 4'h4, 1'b1);
      alu_op("ADD0", 4'h2, 1'b0, 1'b0);
      branch_op("JZ_N", 4'h5, 1'b0);
      branch_op("JC_N", 4'h6, 1'b0);
      branch_op("JMP0", 4'h4, 1'b1);
`else
      fetch("OP4", 4'h4);
      fetch("OP5", 4'h5);
      fetch("OP6", 4'h6);
`endif
      fetch("UNDEF", 4'hA);
      alu_op("SUB2", 4'h3, 1'b1, 1'b0);

      // Async reset landing in T4 of LDA.
      fetch("LDA_R", 4'h1);
      cyc("LDA_R", 1'b0, 4'h1, 1'b0, 1'b0, 12'h120, 1'b0, 3'd3, 1'b1);
      ez  = 1'b0;
      ecf = 1'b0;
      cyc("RSTMID", 1'b1, 4'h1, 1'b1, 1'b1, 12'h000, 1'b0, 3'd0, 1'b1);
      cyc("RSTHLD", 1'b1, 4'h1, 1'b1, 1'b1, 12'h000, 1'b0, 3'd0, 1'b1);

      fetch("HLT", 4'hF);
      cyc("HLT", 1'b0, 4'hF, 1'b0, 1'b0, 12'h800, 1'b0, 3'd3, 1'b1);
      for (int i = 0; i < 20; i++) begin
         logic [3:0] op;
         op = 4'(i);
         cyc("HALT", 1'b0, op, 1'b1, 1'b1, 12'h800, 1'b0, 3'd0, 1'b0);
      end
      cyc("HLT_RST", 1'b1, 4'h0, 1'b0, 1'b0, 12'h000, 1'b0, 3'd0, 1'b1);
      fetch("POST", 4'h0);
      cyc("POST", 1'b0, 4'h0, 1'b0, 1'b0, 12'h300, 1'b0, 3'd0, 1'b1);

      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d entries left, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
